fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter and fetch-sequencing stage directly upstream of InstructionMemory.
//  Drives the 8-bit word address and captures the returned 32-bit word with its PC.
//  Presents the word to decode through a valid/ready handshake at 1 instr/cycle.
//  Supports decode back-pressure, branch redirect and a halt/resume control.
// PARAMETERS
//  ADDR_W    8          instruction word-address width; must match InstructionMemory
//  DATA_W    32         instruction width
//  RESET_PC  8'h00      first address fetched after reset
// PORTS
//  clk              in   1       system clock, rising edge
//  rst_n            in   1       asynchronous active-low reset
//  imem_addr_o      out  ADDR_W  word address to InstructionMemory (combinational)
//  imem_data_i      in   DATA_W  instruction word = mem[address presented previous cycle]
//  instr_o          out  DATA_W  instruction to decode (= imem_data_i)
//  pc_o             out  ADDR_W  address of instr_o
//  valid_o          out  1       instr_o/pc_o valid
//  ready_i          in   1       decode accepts; transfer when valid_o & ready_i
//  branch_i         in   1       redirect request (single-cycle pulse)
//  branch_target_i  in   ADDR_W  redirect address
//  halt_i           in   1       level: stop issuing new fetches
// BEHAVIOUR
//  - Interface is fixed: one clock (clk); reset rst_n is asynchronous, active-low.
//  - Memory read is synchronous, 1-cycle latency. pc_q <= imem_addr_o every cycle.
//  - Registers: state{START,RUN,HALT}, pc_q[ADDR_W], vld_q.
//  - Reset values: state=START, pc_q=RESET_PC, vld_q=0.
//  - Outputs during reset: valid_o=0, pc_o=RESET_PC, imem_addr_o=RESET_PC.
//  - valid_o = vld_q & ~branch_i;  pc_o = pc_q;  instr_o = imem_data_i.
//  - START: imem_addr_o=RESET_PC; vld_q'=1; ->RUN.
//    First valid_o is in the 2nd cycle after reset release.
//    branch_i in START is ignored.
//  - RUN, priority high->low:
//    1 branch_i: addr=branch_target_i, vld_q'=1.
//      The word on the outputs this cycle is squashed (valid_o=0), even if ready_i=1.
//    2 halt_i: addr=pc_q; vld_q'=vld_q&~ready_i; ->HALT.
//      The current word may still transfer this cycle.
//    3 vld_q&~ready_i (stall): addr=pc_q, vld_q'=1.
//      Re-reading pc_q keeps instr_o stable.
//    4 otherwise: addr=pc_q+1 mod 2^ADDR_W, vld_q'=1.
//  - HALT:
//    - branch_i: as RUN-1; ->RUN.
//    - halt_i=1: addr=pc_q; vld_q'=vld_q&~ready_i (drain the un-accepted word, fetch nothing new).
//    - halt_i=0: addr = (vld_q&~ready_i) ? pc_q : pc_q+1; vld_q'=1; ->RUN.
//  - Wrap-around: 8'hFF+1 -> 8'h00, no flag, no gap.
//  - Stability: while valid_o=1 & ready_i=0 & ~branch_i, instr_o and pc_o hold next cycle.
//  - No duplicate and no skipped PC except via branch.
//  - branch_i together with ready_i=1: no transfer is counted.
//  - Reset mid-operation: everything returns to reset values immediately; in-flight word lost.
//  - Comb paths: ready_i/branch_i/halt_i -> imem_addr_o. No comb path into ready_i.
// TESTING
//  Bench pairs the block with InstructionMemory (word k = 32'h1000_0000+k).
//  Scoreboard compares accepted (pc,instr) pairs.
//  1 Reset release, ready_i=1 held:
//    valid_o=1 from cycle 2; pc_o 0,1,2,3... one per cycle; instr_o=mem[pc_o].
//  2 ready_i=0 for 3 cycles at pc_o=5:
//    pc_o=5 and instr_o stable all 3 cycles; after release 5 is accepted once, then 6.
//  3 branch_i with target 8'h40 while pc_o=9:
//    valid_o=0 that cycle; next cycle pc_o=8'h40; 9 never transfers.
//  4 halt_i at pc_o=3 with ready_i=0, then ready_i=1:
//    3 transfers once, then valid_o=0; on halt_i=0, pc_o=4 next cycle.
//  5 Run from branch to 8'hFE:
//    sequence FE, FF, 00, 01 with no gap.
//  6 rst_n low mid-stream at pc_o=7, released:
//    valid_o=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Program-counter and fetch sequencer feeding a 1-cycle synchronous instruction memory.
// Presents (pc, instr) to decode over valid/ready with branch redirect and halt/resume.
module fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              halt_i
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_s;
  logic              stall_s;

  // A presented word that decode has not taken must be re-read to stay stable.
  assign stall_s = vld_q & ~ready_i;

  // State, pc and valid registers; pc always tracks the address just issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (branch_i) begin
          state_d = ST_RUN;
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (branch_i || !halt_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  // Fetch address and next valid; branch squashes the word on the outputs.
  always_comb begin
    addr_s = pc_q;
    vld_d  = 1'b0;
    case (state_q)
      ST_START: begin
        addr_s = RESET_PC;
        vld_d  = 1'b1;
      end
      ST_RUN: begin
        if (branch_i) begin
          addr_s = branch_target_i;
          vld_d  = 1'b1;
        end else if (halt_i) begin
          addr_s = pc_q;
          vld_d  = stall_s;
        end else if (stall_s) begin
          addr_s = pc_q;
          vld_d  = 1'b1;
        end else begin
          addr_s = pc_q + PC_ONE;
          vld_d  = 1'b1;
        end
      end
      ST_HALT: begin
        if (branch_i) begin
          addr_s = branch_target_i;
          vld_d  = 1'b1;
        end else if (halt_i) begin
          addr_s = pc_q;
          vld_d  = stall_s;
        end else begin
          addr_s = stall_s ? pc_q : (pc_q + PC_ONE);
          vld_d  = 1'b1;
        end
      end
      default: begin
        addr_s = RESET_PC;
        vld_d  = 1'b0;
      end
    endcase
  end

  assign pc_d        = addr_s;
  assign imem_addr_o = addr_s;
  assign instr_o     = imem_data_i;
  assign pc_o        = pc_q;
  assign valid_o     = vld_q & ~branch_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit paired with a behavioural instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] MEM_BASE = 32'h1000_0000;

  typedef struct {
    logic       ready;
    logic       branch;
    logic [7:0] target;
    logic       halt;
    logic       exp_valid;
    logic [7:0] exp_pc;
    logic [7:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = 32'h0000_0000;
  logic [31:0] instr;
  logic [7:0]  pc;
  logic        valid;
  logic        ready = 1'b0;
  logic        branch = 1'b0;
  logic [7:0]  target = 8'h00;
  logic        halt = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  vec_t vecs[36];

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .instr_o(instr), .pc_o(pc), .valid_o(valid), .ready_i(ready),
    .branch_i(branch), .branch_target_i(target), .halt_i(halt)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds MEM_BASE + k, one-cycle read latency.
  always_ff @(posedge clk) imem_data <= MEM_BASE + {24'h000000, imem_addr};

  function automatic vec_t mk(input logic r, input logic b, input logic [7:0] t, input logic h,
                              input logic ev, input logic [7:0] ep, input logic [7:0] ea);
    vec_t v;
    v.ready = r; v.branch = b; v.target = t; v.halt = h;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    ready = v.ready; branch = v.branch; target = v.target; halt = v.halt;
  endtask

  // Compare outputs mid-cycle; expected transfers go into the scoreboard, DUT transfers pop it.
  task automatic check_vec(input vec_t v, input int idx);
    logic [7:0] e;
    chk($sformatf("valid[%0d]", idx), {31'd0, valid}, {31'd0, v.exp_valid});
    chk($sformatf("addr[%0d]", idx), {24'd0, imem_addr}, {24'd0, v.exp_addr});
    if (v.exp_valid) begin
      chk($sformatf("pc[%0d]", idx), {24'd0, pc}, {24'd0, v.exp_pc});
    end
    if (v.exp_valid && v.ready) sb_q.push_back(v.exp_pc);
    if (valid && ready) begin
      if (sb_q.size() == 0) begin
        chk($sformatf("unexpected_xfer[%0d]", idx), {24'd0, pc}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("sb_pc[%0d]", idx), {24'd0, pc}, {24'd0, e});
        chk($sformatf("sb_instr[%0d]", idx), instr, MEM_BASE + {24'd0, e});
      end
    end
  endtask

  initial begin
    //            rdy   br    tgt    halt  ev    pc     addr
    vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    vecs[1]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01);
    vecs[2]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h02);
    vecs[3]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 8'h03);
    vecs[4]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h04);
    vecs[5]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 8'h05);
    vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 8'h05);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 8'h05);
    vecs[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 8'h05);
    vecs[9]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 8'h06);
    vecs[10] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 8'h07);
    vecs[11] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 8'h08);
    vecs[12] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 8'h09);
    vecs[13] = mk(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 8'h09, 8'h40);
    vecs[14] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 8'h41);
    vecs[15] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 8'h42);
    vecs[16] = mk(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 8'h42, 8'h03);
    vecs[17] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h03);
    vecs[18] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h03);
    vecs[19] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h03);
    vecs[20] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 8'h04);
    vecs[21] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 8'h05);
    vecs[22] = mk(1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h05, 8'hFE);
    vecs[23] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFE, 8'hFF);
    vecs[24] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00);
    vecs[25] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01);
    vecs[26] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h02);
    vecs[27] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 8'h02);
    vecs[28] = mk(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h02, 8'h10);
    vecs[29] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h11);
    vecs[30] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 8'h11);
    vecs[31] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'h11);
    vecs[32] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'h12);
    vecs[33] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 8'h13);
    vecs[34] = mk(1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 8'h13, 8'h07);
    vecs[35] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 8'h07);

    // Reset state.
    @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_vec(vecs[i], i);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-stream while pc_o=7 is being presented.
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_pc", {24'd0, pc}, 32'd0);
    chk("midrst_addr", {24'd0, imem_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // branch during START must be ignored.
    drive(mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00));
    @(negedge clk);
    check_vec(mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00), 100);
    @(posedge clk); #1;
    drive(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01));
    @(negedge clk);
    check_vec(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01), 101);
    @(posedge clk); #1;
    drive(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h02));
    @(negedge clk);
    check_vec(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h02), 102);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
